// File: rtl/costas_sched_pkg.sv
// -----------------------------------------------------------------------------
// costas_sched_pkg
// Shared types and constants for the Costas loop update scheduler:
//   - state_t      : sequencing FSM states
//   - DIV_MIN      : shortest period the loop arithmetic is allowed to run at
//   - DIV_DEFAULT  : period length after reset
//   - TRIG_DEFAULT : sampler trigger position after reset
//   - clamp_div / clamp_trig : config sanitising applied at capture time
// -----------------------------------------------------------------------------
package costas_sched_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PD_WAIT = 2'd1,
      LF_WAIT = 2'd2,
      NCO     = 2'd3
   } state_t;

   localparam int unsigned DIV_MIN      = 4;
   localparam int unsigned DIV_DEFAULT  = 15;
   localparam int unsigned TRIG_DEFAULT = 13;

   // A period shorter than DIV_MIN cannot fit the PD -> LF -> NCO sequence.
   function automatic int unsigned clamp_div(input int unsigned div);
      return (div < DIV_MIN) ? DIV_MIN : div;
   endfunction

   // The trigger must land inside the period; div is the already-clamped value.
   function automatic int unsigned clamp_trig(input int unsigned div,
                                              input int unsigned trig);
      return (trig >= div) ? (div - 1) : trig;
   endfunction

endpackage

// File: rtl/costas_tick_divider.sv
// -----------------------------------------------------------------------------
// costas_tick_divider
// Programmable period divider with a one-deep shadow config register.
//   clock, reset      : rising-edge clock, async active-high reset
//   enable            : counter advances only when high
//   cfg_valid/ready   : config handshake; ready is low while a config is pending
//   cfg_div, cfg_trig : period length and trigger position (clamped on capture)
//   tick              : high while count == 0 (one cycle per period)
//   trig              : high while count == trigger position
// -----------------------------------------------------------------------------
module costas_tick_divider
   import costas_sched_pkg::*;
#(
   parameter int CNT_W        = 8,
   parameter int DEFAULT_DIV  = DIV_DEFAULT,
   parameter int DEFAULT_TRIG = TRIG_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_trig,
   output logic             tick,
   output logic             trig
);

   localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(clamp_div(DEFAULT_DIV));
   localparam logic [CNT_W-1:0] RST_TRIG =
      CNT_W'(clamp_trig(clamp_div(DEFAULT_DIV), DEFAULT_TRIG));

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic [CNT_W-1:0] div;
   logic [CNT_W-1:0] trig_pos;
   logic [CNT_W-1:0] shadow_div;
   logic [CNT_W-1:0] shadow_trig;
   logic [CNT_W-1:0] cap_div;
   logic [CNT_W-1:0] cap_trig;
   logic             pending;
   logic             wrap;

   // >= rather than == so a period shortened while enable was low still wraps.
   assign wrap       = enable && (count >= div - CNT_W'(1));
   assign count_next = wrap ? '0 : count + CNT_W'(1);

   // Trigger clamp uses the clamped period so the pair is always consistent.
   assign cap_div  = CNT_W'(clamp_div(32'(cfg_div)));
   assign cap_trig = CNT_W'(clamp_trig(32'(cap_div), 32'(cfg_trig)));

   assign cfg_ready = ~pending;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count       <= '0;
         div         <= RST_DIV;
         trig_pos    <= RST_TRIG;
         shadow_div  <= '0;
         shadow_trig <= '0;
         pending     <= 1'b0;
         tick        <= 1'b0;
         trig        <= 1'b0;
      end else begin
         tick <= wrap;
         trig <= enable && (count_next == trig_pos);
         if (enable) begin
            count <= count_next;
         end
         // Apply only at a period boundary, or at once while the divider is
         // frozen; capture is only possible when nothing is pending.
         if (pending && (wrap || !enable)) begin
            div      <= shadow_div;
            trig_pos <= shadow_trig;
            pending  <= 1'b0;
         end else if (cfg_valid && !pending) begin
            shadow_div  <= cap_div;
            shadow_trig <= cap_trig;
            pending     <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/costas_loop_scheduler.sv
// -----------------------------------------------------------------------------
// costas_loop_scheduler
// Launches one phase-detector -> loop-filter -> NCO-load sequence per period.
//   clock, reset            : rising-edge clock, async active-high reset
//   enable                  : divider advance enable
//   cfg_valid/ready/div/trig: period configuration handshake
//   tick, trig              : period and sampler strobes
//   pd_start / pd_done      : phase detector handshake
//   lf_start / lf_done      : loop filter handshake
//   nco_load                : one-cycle NCO increment load
//   busy                    : sequence in flight
//   clr_overrun             : clears overrun flag and count
//   overrun, overrun_cnt    : sticky flag and saturating count of dropped ticks
// All outputs are registered.
// -----------------------------------------------------------------------------
module costas_loop_scheduler
   import costas_sched_pkg::*;
#(
   parameter int CNT_W        = 8,
   parameter int DEFAULT_DIV  = 15,
   parameter int DEFAULT_TRIG = 13
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_trig,
   output logic             tick,
   output logic             trig,
   output logic             pd_start,
   input  logic             pd_done,
   output logic             lf_start,
   input  logic             lf_done,
   output logic             nco_load,
   output logic             busy,
   input  logic             clr_overrun,
   output logic             overrun,
   output logic [7:0]       overrun_cnt
);

   state_t state;
   state_t state_next;
   logic   pd_start_next;
   logic   lf_start_next;
   logic   overrun_event;

   costas_tick_divider #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .DEFAULT_TRIG(DEFAULT_TRIG)
   ) u_divider (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_div  (cfg_div),
      .cfg_trig (cfg_trig),
      .tick     (tick),
      .trig     (trig)
   );

   // A tick arriving mid-sequence is dropped; the sequence in flight carries on.
   assign overrun_event = tick && (state != IDLE);

   // NOTE: every signal driven here gets a default first, so no path through
   // the case can leave it unassigned and infer a latch.
   always_comb begin
      state_next    = state;
      pd_start_next = 1'b0;
      lf_start_next = 1'b0;
      unique case (state)
         IDLE: begin
            if (tick) begin
               state_next    = PD_WAIT;
               pd_start_next = 1'b1;
            end
         end
         PD_WAIT: begin
            if (pd_done) begin
               state_next    = LF_WAIT;
               lf_start_next = 1'b1;
            end
         end
         LF_WAIT: begin
            if (lf_done) begin
               state_next = NCO;
            end
         end
         NCO: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Strobes are registered from the transition, so each is high exactly for
   // the first cycle spent in its target state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         pd_start <= 1'b0;
         lf_start <= 1'b0;
         nco_load <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_next;
         pd_start <= pd_start_next;
         lf_start <= lf_start_next;
         nco_load <= (state_next == NCO);
         busy     <= (state_next != IDLE);
      end
   end

   // Clear has priority over a simultaneous overrun event.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overrun     <= 1'b0;
         overrun_cnt <= '0;
      end else if (clr_overrun) begin
         overrun     <= 1'b0;
         overrun_cnt <= '0;
      end else if (overrun_event) begin
         overrun <= 1'b1;
         if (overrun_cnt != 8'hFF) begin
            overrun_cnt <= overrun_cnt + 8'd1;
         end
      end
   end

endmodule

// File: doc/costas_loop_scheduler.md
# costas_loop_scheduler

Sequences one Costas loop update per symbol period. It runs a programmable period divider, a generalisation of the fixed divide-by-15 tick generator. Each period boundary launches a three-step handshake sequence: phase detector, then loop filter, then NCO load. The block sits between the sample-rate clock domain logic and the loop arithmetic units, which it drives. It flags overruns when the arithmetic cannot finish within one period.

## Interface
Parameters:
- CNT_W, 8, width of divider counter and config fields
- DEFAULT_DIV, 15, period length in clocks after reset
- DEFAULT_TRIG, 13, count value at which trig asserts after reset

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  divider advances only when high
- cfg_valid  in  1  new div/trig offered
- cfg_ready  out  1  high when no config is pending
- cfg_div  in  CNT_W  period in clocks
- cfg_trig  in  CNT_W  trig position within period
- tick  out  1  one-cycle period strobe
- trig  out  1  one-cycle mid-period strobe (sampler trigger)
- pd_start  out  1  one-cycle start to phase detector
- pd_done  in  1  phase detector result ready
- lf_start  out  1  one-cycle start to loop filter
- lf_done  in  1  loop filter result ready
- nco_load  out  1  one-cycle NCO increment load
- busy  out  1  FSM not IDLE
- clr_overrun  in  1  clears overrun and overrun_cnt
- overrun  out  1  sticky overrun flag
- overrun_cnt  out  8  saturating overrun count

## Operation
- Divider:
  - count increments on each edge with enable high.
  - On the edge where count == div-1, count wraps to 0 and tick is set for one cycle. tick is high while count == 0.
  - trig is set on the edge where count becomes trig, so trig is high while count == trig.
- Config clamp:
  - div < 4 is treated as 4.
  - trig >= div is treated as div-1.
  - Clamping is applied when the config is captured.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready. Values go to a shadow register; cfg_ready drops.
  - The shadow is applied on the next wrap edge, or on the next edge if enable is low. cfg_ready rises the cycle after it is applied.
  - A second config cannot be accepted while one is pending.
- FSM states: IDLE, PD_WAIT, LF_WAIT, NCO.
  - IDLE → PD_WAIT when tick is high. pd_start is high for the first cycle in PD_WAIT.
  - PD_WAIT → LF_WAIT when pd_done is high. This includes the pd_start cycle. lf_start is high for the first cycle in LF_WAIT.
  - LF_WAIT → NCO when lf_done is high, same rule. nco_load is high for the single NCO cycle.
  - NCO → IDLE unconditionally.
  - done inputs are ignored outside their wait state.
- Overrun:
  - tick high while the FSM is not IDLE sets overrun and increments overrun_cnt, saturating at 255. The tick is dropped and the sequence in flight continues.
  - If clr_overrun and an overrun occur in the same cycle, clear wins.
- enable low: the divider holds and generates no tick or trig. The in-flight FSM sequence completes normally.
- Reset mid-operation:
  - count=0, FSM=IDLE, div=DEFAULT_DIV, trig=DEFAULT_TRIG.
  - Shadow config is discarded.

## Timing
- Reset values:
  - tick, trig, pd_start, lf_start, nco_load, busy, overrun = 0.
  - overrun_cnt = 0, cfg_ready = 1.
- First tick occurs div enabled edges after reset release.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Minimum sequence (done inputs tied high):
  - tick at cycle T.
  - pd_start at T+1, lf_start at T+2, nco_load at T+3.
  - IDLE again at T+4.
- With div = 4 and zero-latency arithmetic, no overrun occurs.
- busy is high from T+1 through T+3.

## Structure
- Package costas_sched_pkg holds:
  - the state enum;
  - DIV_MIN = 4;
  - the default constants;
  - the clamp function for div/trig.
- One sub-module, costas_tick_divider, contains the counter, shadow config, and tick/trig generation. The FSM and overrun logic stay in the top level.

## Test plan
- Reset, enable=1, defaults, pd_done=lf_done=1:
  - tick every 15 cycles; trig 13 cycles after each tick.
  - pd_start/lf_start/nco_load at +1/+2/+3 from tick; overrun stays 0.
- cfg_div=4, cfg_trig=9 accepted mid-period:
  - old period finishes; new period is 4; trig clamped to count 3.
  - cfg_ready is low until the cycle after the wrap edge.
- cfg_div=1: period is clamped to 4.
- pd_done withheld for 20 cycles at div=15:
  - overrun=1 and overrun_cnt=1 at the second tick.
  - lf_start follows pd_done by one cycle; the dropped tick yields no extra pd_start.
- clr_overrun pulsed coincident with an overrun event: overrun=0 and overrun_cnt=0 next cycle.
- enable low for 10 cycles mid-period: count frozen, no tick or trig, the pending sequence still completes.
- reset asserted during LF_WAIT:
  - all outputs are 0 immediately.
  - After release, the first tick occurs after 15 enabled edges with no stray nco_load.
